phase_detector: RTL

PHASE_DETECTOR -- requirements
Module: phase_detector

---
 rtl/phase_detector_pkg.sv | 19 +
 rtl/phase_detector_if.sv | 13 +
 rtl/phase_detector_edge_sync.sv | 34 +++
 rtl/phase_detector.sv | 138 +++++++++++++
 4 files changed

// File: rtl/phase_detector_pkg.sv
// Shared types and defaults for the bang-bang phase detector.
package phase_detector_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REF_LEAD = 2'd1,
    FB_LEAD  = 2'd2,
    STROBE   = 2'd3
  } pd_state_t;

  localparam int CNT_W          = 8;
  localparam int STROBE_LEN_DEF = 4;
  localparam int TIMEOUT_DEF    = 200;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/phase_detector_if.sv
// Detector-to-loop-controller bundle: direction pulses, comparison strobe and lead magnitude.
interface phase_detector_if;
  import phase_detector_pkg::*;

  logic             p_up;
  logic             p_down;
  logic             phase_clk;
  logic [CNT_W-1:0] phase_err;

  modport master (output p_up, output p_down, output phase_clk, output phase_err);
  modport slave  (input  p_up, input  p_down, input  phase_clk, input  phase_err);

endinterface

// File: rtl/phase_detector_edge_sync.sv
// Two-flop synchronizer plus history flop; rise pulses one clk cycle per rising edge of d.
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic s1, s2, hist;
  logic fill1, fill2, armed;

  // armed only sets once a genuine low has been seen after reset, so a level
  // that was already high when reset released never reports an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      hist  <= 1'b0;
      fill1 <= 1'b0;
      fill2 <= 1'b0;
      armed <= 1'b0;
    end else begin
      s1    <= d;
      s2    <= s1;
      hist  <= s2;
      fill1 <= 1'b1;
      fill2 <= fill1;
      if (fill2 && !s2) armed <= 1'b1;
    end
  end

  assign rise = s2 & ~hist & armed;

endmodule

// File: rtl/phase_detector.sv
// Measures which of ref_in/fb_in rises first and by how many clk cycles, then strobes the result.
//
// state    | meaning
// IDLE     | waiting for an edge (live or pending) on either input
// REF_LEAD | ref has risen, counting until fb rises or timeout; p_up high
// FB_LEAD  | fb has risen, counting until ref rises or timeout; p_down high
// STROBE   | phase_clk high for STROBE_LEN cycles; edges seen here are held pending
module phase_detector
  import phase_detector_pkg::*;
#(
  parameter int STROBE_LEN = STROBE_LEN_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ref_in,
  input  logic              fb_in,
  phase_detector_if.master  pd
);

  localparam logic [3:0]       STB_LOAD = 4'(STROBE_LEN - 1);
  localparam logic [CNT_W-1:0] TO_CNT   = CNT_W'(TIMEOUT);

  logic ref_rise, fb_rise;

  edge_sync u_ref_sync (.clk(clk), .reset(reset), .d(ref_in), .rise(ref_rise));
  edge_sync u_fb_sync  (.clk(clk), .reset(reset), .d(fb_in),  .rise(fb_rise));

  pd_state_t        state_q, state_d;
  logic [CNT_W-1:0] lead_q, lead_d;
  logic [3:0]       stb_q, stb_d;
  logic             pend_ref_q, pend_ref_d, pend_fb_q, pend_fb_d;
  logic             p_up_q, p_up_d, p_down_q, p_down_d, phase_clk_q, phase_clk_d;
  logic [CNT_W-1:0] phase_err_q, phase_err_d;
  logic             ev_ref, ev_fb;

  assign ev_ref = ref_rise | pend_ref_q;
  assign ev_fb  = fb_rise  | pend_fb_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      lead_q      <= '0;
      stb_q       <= '0;
      pend_ref_q  <= 1'b0;
      pend_fb_q   <= 1'b0;
      p_up_q      <= 1'b0;
      p_down_q    <= 1'b0;
      phase_clk_q <= 1'b0;
      phase_err_q <= '0;
    end else begin
      state_q     <= state_d;
      lead_q      <= lead_d;
      stb_q       <= stb_d;
      pend_ref_q  <= pend_ref_d;
      pend_fb_q   <= pend_fb_d;
      p_up_q      <= p_up_d;
      p_down_q    <= p_down_d;
      phase_clk_q <= phase_clk_d;
      phase_err_q <= phase_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ev_ref && ev_fb) state_d = STROBE;
        else if (ev_ref)     state_d = REF_LEAD;
        else if (ev_fb)      state_d = FB_LEAD;
      end
      REF_LEAD: if (fb_rise  || lead_q == TO_CNT) state_d = STROBE;
      FB_LEAD:  if (ref_rise || lead_q == TO_CNT) state_d = STROBE;
      STROBE:   if (stb_q == '0) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    lead_d      = lead_q;
    stb_d       = stb_q;
    pend_ref_d  = pend_ref_q;
    pend_fb_d   = pend_fb_q;
    p_up_d      = 1'b0;
    p_down_d    = 1'b0;
    phase_clk_d = 1'b0;
    phase_err_d = phase_err_q;
    case (state_q)
      IDLE: begin
        pend_ref_d = 1'b0;
        pend_fb_d  = 1'b0;
        lead_d     = CNT_W'(1);
        stb_d      = STB_LOAD;
        if (ev_ref && ev_fb) begin
          phase_err_d = '0;
          phase_clk_d = 1'b1;
        end else if (ev_ref) begin
          p_up_d = 1'b1;
        end else if (ev_fb) begin
          p_down_d = 1'b1;
        end
      end
      REF_LEAD: begin
        if (fb_rise || lead_q == TO_CNT) begin
          phase_err_d = lead_q;
          phase_clk_d = 1'b1;
        end else begin
          lead_d = sat_inc(lead_q);
          p_up_d = 1'b1;
        end
      end
      FB_LEAD: begin
        if (ref_rise || lead_q == TO_CNT) begin
          phase_err_d = lead_q;
          phase_clk_d = 1'b1;
        end else begin
          lead_d   = sat_inc(lead_q);
          p_down_d = 1'b1;
        end
      end
      STROBE: begin
        pend_ref_d = pend_ref_q | ref_rise;
        pend_fb_d  = pend_fb_q  | fb_rise;
        if (stb_q != '0) begin
          stb_d       = stb_q - 4'd1;
          phase_clk_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign pd.p_up      = p_up_q;
  assign pd.p_down    = p_down_q;
  assign pd.phase_clk = phase_clk_q;
  assign pd.phase_err = phase_err_q;

endmodule
